// File: rtl/draw_monster.sv
// draw_monster: overlays a 16x16 animated monster sprite on the upstream
// pixel stream. Two pipeline stages: stage 1 registers timing, the window
// flag and the ROM address; stage 2 picks ROM or upstream colour.
module draw_monster #(
    parameter logic [23:0] TRANSPARENT   = 24'hFF00FF,
    parameter int          ANIM_FRAMES   = 15,
    parameter int          SQUASH_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blnk_in,
    input  logic [23:0] rgb_in,
    input  logic [9:0]  xpos,
    input  logic [8:0]  ypos,
    input  logic        direction,
    input  logic        spawn,
    input  logic        kill,
    input  logic [23:0] rom_data,
    output logic [9:0]  rom_addr,
    output logic [9:0]  hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blnk_out,
    output logic [23:0] rgb_out,
    output logic [1:0]  monster_state
);

    localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int SW = (SQUASH_FRAMES > 1) ? $clog2(SQUASH_FRAMES + 1) : 1;
    localparam logic [AW-1:0] ANIM_LAST   = AW'(ANIM_FRAMES - 1);
    localparam logic [SW-1:0] SQUASH_LOAD = SW'(SQUASH_FRAMES);
    localparam logic [SW-1:0] SQUASH_ONE  = SW'(1);

    typedef enum logic [1:0] {
        ST_DEAD     = 2'b00,
        ST_ALIVE    = 2'b01,
        ST_SQUASHED = 2'b10
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   anim_cnt_r;
    logic            anim_r;
    logic [SW-1:0]   squash_cnt_r;
    logic [9:0]      lat_x_r;
    logic [8:0]      lat_y_r;
    logic            lat_dir_r;

    logic [9:0]      hcount_d1_r;
    logic [9:0]      vcount_d1_r;
    logic            hsync_d1_r;
    logic            vsync_d1_r;
    logic            blnk_d1_r;
    logic [23:0]     rgb_d1_r;
    logic            in_win_d1_r;

    logic            frame_tick_s;
    logic [10:0]     h_ext_s;
    logic [10:0]     v_ext_s;
    logic [10:0]     x_ext_s;
    logic [10:0]     y_ext_s;
    logic            in_win_s;
    logic [3:0]      dx_s;
    logic [3:0]      dy_s;
    logic [3:0]      col_s;
    logic [1:0]      frame_s;
    logic [9:0]      rom_addr_s;
    logic            draw_s;

    // Frame tick, 11-bit window test (no wrap at right/bottom) and ROM address.
    always_comb begin
        frame_tick_s = (hcount_in == 10'd0) && (vcount_in == 10'd480);
        h_ext_s      = {1'b0, hcount_in};
        v_ext_s      = {1'b0, vcount_in};
        x_ext_s      = {1'b0, lat_x_r};
        y_ext_s      = {2'b00, lat_y_r};
        in_win_s     = (h_ext_s >= x_ext_s) && (h_ext_s < (x_ext_s + 11'd16)) &&
                       (v_ext_s >= y_ext_s) && (v_ext_s < (y_ext_s + 11'd16));
        // Only the low nibble of the offset matters inside the window.
        dx_s         = hcount_in[3:0] - lat_x_r[3:0];
        dy_s         = vcount_in[3:0] - lat_y_r[3:0];
        if (lat_dir_r) begin
            col_s = dx_s;
        end else begin
            col_s = 4'd15 - dx_s;
        end
        case (state_r)
            ST_ALIVE:    frame_s = {1'b0, anim_r};
            ST_SQUASHED: frame_s = 2'b10;
            default:     frame_s = 2'b00;
        endcase
        rom_addr_s = {frame_s, dy_s, col_s};
    end

    // Stage-2 colour select: sprite pixel only when visible and opaque.
    always_comb begin
        draw_s = in_win_d1_r && !blnk_d1_r && (state_r != ST_DEAD) &&
                 (rom_data != TRANSPARENT);
    end

    // Latch position and facing once per frame so a frame is drawn consistently.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_x_r   <= 10'd0;
            lat_y_r   <= 9'd0;
            lat_dir_r <= 1'b0;
        end else if (frame_tick_s) begin
            lat_x_r   <= xpos;
            lat_y_r   <= ypos;
            lat_dir_r <= direction;
        end
    end

    // Monster life-cycle FSM with walk-animation and squash-display counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_DEAD;
            anim_cnt_r   <= '0;
            anim_r       <= 1'b0;
            squash_cnt_r <= '0;
        end else if (spawn) begin
            state_r      <= ST_ALIVE;
            anim_cnt_r   <= '0;
            anim_r       <= 1'b0;
            squash_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_DEAD: begin
                    anim_cnt_r <= '0;
                end
                ST_ALIVE: begin
                    if (kill) begin
                        state_r      <= ST_SQUASHED;
                        squash_cnt_r <= SQUASH_LOAD;
                        anim_cnt_r   <= '0;
                    end else if (frame_tick_s) begin
                        if (anim_cnt_r == ANIM_LAST) begin
                            anim_cnt_r <= '0;
                            anim_r     <= ~anim_r;
                        end else begin
                            anim_cnt_r <= anim_cnt_r + AW'(1);
                        end
                    end
                end
                ST_SQUASHED: begin
                    anim_cnt_r <= '0;
                    if (frame_tick_s) begin
                        if (squash_cnt_r <= SQUASH_ONE) begin
                            state_r      <= ST_DEAD;
                            squash_cnt_r <= '0;
                        end else begin
                            squash_cnt_r <= squash_cnt_r - SW'(1);
                        end
                    end
                end
                default: begin
                    state_r      <= ST_DEAD;
                    anim_cnt_r   <= '0;
                    squash_cnt_r <= '0;
                end
            endcase
        end
    end

    // Stage 1: register timing, upstream colour, window flag and ROM address.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_d1_r <= 10'd0;
            vcount_d1_r <= 10'd0;
            hsync_d1_r  <= 1'b0;
            vsync_d1_r  <= 1'b0;
            blnk_d1_r   <= 1'b0;
            rgb_d1_r    <= 24'd0;
            in_win_d1_r <= 1'b0;
            rom_addr    <= 10'd0;
        end else begin
            hcount_d1_r <= hcount_in;
            vcount_d1_r <= vcount_in;
            hsync_d1_r  <= hsync_in;
            vsync_d1_r  <= vsync_in;
            blnk_d1_r   <= blnk_in;
            rgb_d1_r    <= rgb_in;
            in_win_d1_r <= in_win_s;
            rom_addr    <= rom_addr_s;
        end
    end

    // Stage 2: registered outputs to the next draw stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= 10'd0;
            vcount_out <= 10'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            blnk_out   <= 1'b0;
            rgb_out    <= 24'd0;
        end else begin
            hcount_out <= hcount_d1_r;
            vcount_out <= vcount_d1_r;
            hsync_out  <= hsync_d1_r;
            vsync_out  <= vsync_d1_r;
            blnk_out   <= blnk_d1_r;
            rgb_out    <= draw_s ? rom_data : rgb_d1_r;
        end
    end

    assign monster_state = state_r;

endmodule

// File: tb/tb_draw_monster.sv
// Directed self-checking bench for draw_monster with a behavioural sprite ROM.
module tb_draw_monster;

    logic        clk;
    logic        rst;
    logic [9:0]  hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        blnk_in;
    logic [23:0] rgb_in;
    logic [9:0]  xpos;
    logic [8:0]  ypos;
    logic        direction;
    logic        spawn;
    logic        kill;
    logic [23:0] rom_data;
    logic [9:0]  rom_addr;
    logic [9:0]  hcount_out;
    logic [9:0]  vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        blnk_out;
    logic [23:0] rgb_out;
    logic [1:0]  monster_state;
    logic        force_transp;

    int checks;
    int failures;

    draw_monster dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blnk_in(blnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .direction(direction),
        .spawn(spawn), .kill(kill), .rom_data(rom_data), .rom_addr(rom_addr),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blnk_out(blnk_out),
        .rgb_out(rgb_out), .monster_state(monster_state)
    );

    // ROM content encodes its own address so every fetched pixel is recognisable.
    assign rom_data = force_transp ? 24'hFF00FF : {8'hA5, 6'h00, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold one pixel; check the stage-1 address, then the stage-2 colour.
    task automatic pix(input string tag, input logic [9:0] h, input logic [9:0] v,
                       input logic bl, input logic [23:0] rgb, input logic chk_addr,
                       input logic [9:0] exp_addr, input logic [23:0] exp_rgb);
        @(negedge clk);
        hcount_in = h; vcount_in = v; blnk_in = bl; rgb_in = rgb;
        @(negedge clk);
        if (chk_addr) chk({tag, "_addr"}, rom_addr, exp_addr);
        @(negedge clk);
        chk({tag, "_rgb"}, rgb_out, exp_rgb);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hcount_in = 10'd0; vcount_in = 10'd480; blnk_in = 1'b1;
            @(negedge clk);
            hcount_in = 10'd1;
        end
    endtask

    logic [46:0] d0;
    logic [46:0] d1;
    int          nd;
    logic [9:0]  vlist [5];

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; spawn = 1'b0; kill = 1'b0; force_transp = 1'b0;
        hcount_in = 10'd77; vcount_in = 10'd33; hsync_in = 1'b1; vsync_in = 1'b1;
        blnk_in = 1'b1; rgb_in = 24'hABCDEF;
        xpos = 10'd0; ypos = 9'd0; direction = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("reset_outputs", {rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
                              blnk_out, rgb_out, monster_state}, 64'd0);
        rst = 1'b0;

        // Pass-through sweep: every output is the input from two cycles earlier
        vlist = '{10'd0, 10'd1, 10'd479, 10'd480, 10'd481};
        nd = 0; d0 = '0; d1 = '0;
        for (int vi = 0; vi < 5; vi++) begin
            for (int h = 0; h < 800; h++) begin
                @(negedge clk);
                if (nd >= 2)
                    chk("sweep", {hcount_out, vcount_out, hsync_out, vsync_out, blnk_out, rgb_out}, d1);
                hcount_in = 10'(h); vcount_in = vlist[vi];
                hsync_in  = hcount_in[4]; vsync_in = vcount_in[0];
                blnk_in   = (h >= 640); rgb_in = 24'h123456;
                d1 = d0;
                d0 = {hcount_in, vcount_in, hsync_in, vsync_in, blnk_in, rgb_in};
                nd++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("sweep_drain", {hcount_out, vcount_out, hsync_out, vsync_out, blnk_out, rgb_out}, d1);
            d1 = d0;
        end
        hsync_in = 1'b0; vsync_in = 1'b0;

        // Spawn, position (100,200) facing right
        @(negedge clk); spawn = 1'b1;
        @(negedge clk); spawn = 1'b0;
        chk("spawn_state", monster_state, 2'b01);
        xpos = 10'd100; ypos = 9'd200; direction = 1'b1;
        tick(1);
        pix("tl",     10'd100, 10'd200, 1'b0, 24'h0000AA, 1'b1, 10'h000, 24'hA50000);
        pix("br",     10'd115, 10'd215, 1'b0, 24'h0000BB, 1'b1, 10'h0FF, 24'hA500FF);
        pix("left",   10'd99,  10'd200, 1'b0, 24'h0000CC, 1'b0, 10'h000, 24'h0000CC);
        pix("right",  10'd116, 10'd200, 1'b0, 24'h0000DD, 1'b0, 10'h000, 24'h0000DD);

        // Facing left mirrors the column; transparency and blanking pass through
        direction = 1'b0;
        tick(1);
        pix("mirror", 10'd100, 10'd200, 1'b0, 24'h111111, 1'b1, 10'h00F, 24'hA5000F);
        force_transp = 1'b1;
        pix("transp", 10'd100, 10'd200, 1'b0, 24'h222222, 1'b1, 10'h00F, 24'h222222);
        force_transp = 1'b0;
        pix("blank",  10'd100, 10'd200, 1'b1, 24'h333333, 1'b0, 10'h000, 24'h333333);

        // Bottom-right corner: clipped, no wrap to x/y 0..5
        xpos = 10'd630; ypos = 9'd470; direction = 1'b1;
        tick(1);
        pix("edge_tl", 10'd630, 10'd470, 1'b0, 24'h444444, 1'b1, 10'h000, 24'hA50000);
        pix("edge_br", 10'd639, 10'd479, 1'b0, 24'h555555, 1'b1, 10'h099, 24'hA50099);
        pix("wrap_x0", 10'd0,   10'd470, 1'b0, 24'h666666, 1'b0, 10'h000, 24'h666666);
        pix("wrap_x5", 10'd5,   10'd470, 1'b0, 24'h777777, 1'b0, 10'h000, 24'h777777);
        pix("wrap_y0", 10'd630, 10'd0,   1'b0, 24'h888888, 1'b0, 10'h000, 24'h888888);
        pix("wrap_y5", 10'd630, 10'd5,   1'b0, 24'h999999, 1'b0, 10'h000, 24'h999999);

        // Walk animation toggles on the 15th tick after spawn
        tick(11);
        pix("anim14", 10'd630, 10'd470, 1'b0, 24'h010101, 1'b1, 10'h000, 24'hA50000);
        tick(1);
        pix("anim15", 10'd630, 10'd470, 1'b0, 24'h020202, 1'b1, 10'h100, 24'hA50100);

        // Kill: squashed frame for 30 ticks, then gone
        @(negedge clk); kill = 1'b1;
        @(negedge clk); kill = 1'b0;
        chk("kill_state", monster_state, 2'b10);
        pix("squash", 10'd630, 10'd470, 1'b0, 24'h030303, 1'b1, 10'h200, 24'hA50200);
        tick(29);
        chk("squash29", monster_state, 2'b10);
        tick(1);
        chk("squash30", monster_state, 2'b00);
        pix("dead", 10'd630, 10'd470, 1'b0, 24'h040404, 1'b0, 10'h000, 24'h040404);

        // Spawn together with kill: spawn wins and clears the animation
        @(negedge clk); spawn = 1'b1;
        @(negedge clk); spawn = 1'b0;
        tick(15);
        pix("anim_b", 10'd630, 10'd470, 1'b0, 24'h050505, 1'b1, 10'h100, 24'hA50100);
        @(negedge clk); spawn = 1'b1; kill = 1'b1;
        @(negedge clk); spawn = 1'b0; kill = 1'b0;
        chk("spawn_kill_state", monster_state, 2'b01);
        pix("anim_clr", 10'd630, 10'd470, 1'b0, 24'h060606, 1'b1, 10'h000, 24'hA50000);

        // Reset while squashed beats a simultaneous spawn
        @(negedge clk); kill = 1'b1;
        @(negedge clk); kill = 1'b0;
        chk("kill2_state", monster_state, 2'b10);
        rst = 1'b1; spawn = 1'b1;
        hcount_in = 10'd300; vcount_in = 10'd100; hsync_in = 1'b1; rgb_in = 24'hFEDCBA;
        @(negedge clk);
        chk("rst_squashed", {rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
                             blnk_out, rgb_out, monster_state}, 64'd0);
        rst = 1'b0; spawn = 1'b0; hsync_in = 1'b0;
        pix("post_rst", 10'd630, 10'd470, 1'b0, 24'h070707, 1'b0, 10'h000, 24'h070707);

        // Latched position/direction were cleared: spawn draws mirrored at (0,0)
        @(negedge clk); spawn = 1'b1;
        @(negedge clk); spawn = 1'b0;
        pix("origin", 10'd0, 10'd0, 1'b0, 24'h080808, 1'b1, 10'h00F, 24'hA5000F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/draw_monster.md
DRAW_MONSTER -- requirements
Module: draw_monster

Interface
REQ-001 Parameter TRANSPARENT, default 24'hFF00FF, ROM colour treated as see-through.
REQ-002 Parameter ANIM_FRAMES, default 15, video frames per walk-animation toggle.
REQ-003 Parameter SQUASH_FRAMES, default 30, video frames the squashed sprite is shown before removal.
REQ-004 clk  in  1  pixel clock (25 MHz); single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 hcount_in / vcount_in  in  10 / 10  pixel coordinates from the upstream draw stage.
REQ-007 hsync_in, vsync_in, blnk_in  in  1 each  timing from the upstream draw stage.
REQ-008 rgb_in  in  24  upstream pixel colour.
REQ-009 xpos  in  10  monster left edge, screen pixels; ypos  in  9  monster top edge.
REQ-010 direction  in  1  1 = facing right (ROM as stored), 0 = facing left (mirrored).
REQ-011 spawn  in  1  one-cycle pulse: monster becomes alive.
REQ-012 kill  in  1  one-cycle pulse: monster is stomped.
REQ-013 rom_data  in  24  sprite ROM data, combinational (asynchronous) read of rom_addr.
REQ-014 rom_addr  out  10  {frame[1:0], row[3:0], col[3:0]}.
REQ-015 hcount_out, vcount_out, hsync_out, vsync_out, blnk_out, rgb_out  out  10,10,1,1,1,24  to the next draw stage.
REQ-016 monster_state  out  2  00 DEAD, 01 ALIVE, 10 SQUASHED.

Function
REQ-017 Sprite is 16x16 pixels; ROM frame 0 = walk A, 1 = walk B, 2 = squashed, 3 unused.
REQ-018 Frame tick is a one-cycle internal strobe when hcount_in == 0 and vcount_in == 480.
REQ-019 xpos, ypos and direction are latched only on the frame tick; the drawn image uses the latched values for the whole next frame.
REQ-020 Pixel is in-window when latched_x <= hcount_in < latched_x+16 and latched_y <= vcount_in < latched_y+16, computed at 11 bits so there is no wrap at the right or bottom edge.
REQ-021 row = vcount_in - latched_y; col = hcount_in - latched_x when direction = 1, else 15 - (hcount_in - latched_x).
REQ-022 Stage 1 registers the timing inputs, rgb_in, the in-window flag and rom_addr; stage 2 registers rgb_out from rom_data.
REQ-023 All timing outputs equal the corresponding inputs delayed by exactly 2 clk cycles.
REQ-024 rgb_out = rom_data when in-window, blnk is 0, monster_state != DEAD and rom_data != TRANSPARENT; otherwise rgb_in delayed 2 cycles.
REQ-025 Frame select: ALIVE uses walk A/B by anim bit; SQUASHED uses frame 2.
REQ-026 Anim counter counts frame ticks 0..ANIM_FRAMES-1, wraps to 0, toggles anim bit on wrap; it is held at 0 outside ALIVE.
REQ-027 FSM DEAD -spawn-> ALIVE; ALIVE -kill-> SQUASHED with squash counter loaded to SQUASH_FRAMES.
REQ-028 FSM SQUASHED decrements the counter on each frame tick and moves to DEAD on the tick that takes it from 1 to 0.
REQ-029 spawn from any state -> ALIVE with anim counter and anim bit cleared.
REQ-030 spawn and kill in the same cycle: spawn wins; kill in DEAD or SQUASHED is ignored.
REQ-031 State changes take effect from the next clk cycle; a change mid-frame affects pixels still in the pipeline.

Reset
REQ-032 On rst, all output registers are 0, monster_state = DEAD, the anim and squash counters and the anim bit are 0, and the latched position and direction are 0.
REQ-033 rst has priority over spawn, kill and the frame tick, including while SQUASHED.
REQ-034 One cycle after rst deasserts, the block passes rgb_in through with 2-cycle latency and draws nothing until spawn.

Verification
REQ-035 Scenario: after reset, sweep a full frame with rgb_in = 24'h123456 -> rgb_out = 24'h123456 at every pixel, 2 cycles late, with all syncs delayed by 2.
REQ-036 Scenario: spawn, then xpos=100, ypos=200, direction=1, then a frame tick -> at (100,200), rom_addr = 10'h000; at (115,215), rom_addr = 10'h0FF; at (99,200) and (116,200), rgb_out = rgb_in.
REQ-037 Scenario: direction=0, same position -> at (100,200), col = 15 (rom_addr = 10'h00F); rom_data = TRANSPARENT -> rgb_out = rgb_in.
REQ-038 Scenario: xpos=630, ypos=470 -> only columns 630..639 and rows 470..479 are drawn, with no pixels at x 0..5 or y 0..5.
REQ-039 Scenario: kill while ALIVE -> monster_state = 10 next cycle and frame 2 addresses are used; after 30 frame ticks -> DEAD and the sprite is not drawn.
REQ-040 Scenario: spawn and kill asserted together in ALIVE -> ALIVE, anim counter cleared; rst asserted while SQUASHED -> DEAD with all outputs 0 next cycle.
